ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_if.sv | 39 +++
 rtl/ex_mem_stage.sv | 143 ++++++++++++++
 tb/tb_ex_mem_stage.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_if.sv
// EX->MEM pipeline boundary: EX-side instruction fields in, registered MEM-side fields out.
// master drives the EX side and control; slave is the pipeline register itself.
interface ex_mem_if;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [7:0]  ex_alucontrol;
    logic [31:0] ex_aluout;
    logic        ex_overflow;
    logic [31:0] ex_rtvalue;
    logic [4:0]  ex_writereg;
    logic        ex_regwrite;
    logic [31:0] ex_pc;
    logic        mem_valid;
    logic [31:0] mem_aluout;
    logic [4:0]  mem_writereg;
    logic        mem_regwrite;
    logic [31:0] mem_pc;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_wdata;
    logic        mem_exc;
    logic [4:0]  mem_excode;
    logic [31:0] mem_badvaddr;

    modport master (
        output stall, flush, ex_valid, ex_alucontrol, ex_aluout, ex_overflow,
               ex_rtvalue, ex_writereg, ex_regwrite, ex_pc,
        input  mem_valid, mem_aluout, mem_writereg, mem_regwrite, mem_pc,
               mem_en, mem_wen, mem_wdata, mem_exc, mem_excode, mem_badvaddr
    );

    modport slave (
        input  stall, flush, ex_valid, ex_alucontrol, ex_aluout, ex_overflow,
               ex_rtvalue, ex_writereg, ex_regwrite, ex_pc,
        output mem_valid, mem_aluout, mem_writereg, mem_regwrite, mem_pc,
               mem_en, mem_wen, mem_wdata, mem_exc, mem_excode, mem_badvaddr
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: decodes memory access, aligns store data and byte
// enables, and flags overflow / misaligned-address exceptions.
module ex_mem_stage #(
    parameter logic [4:0] EXC_OV   = 5'h0C,
    parameter logic [4:0] EXC_ADEL = 5'h04,
    parameter logic [4:0] EXC_ADES = 5'h05
) (
    input  logic   clk,
    input  logic   rst,
    ex_mem_if.slave bus
);
    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;

    logic        is_load, is_store, is_half, is_word, addr_err, exc;
    logic [3:0]  wen_raw;
    logic [31:0] wdata_raw;
    logic [31:0] addr;

    logic        n_valid, n_regwrite, n_en, n_exc;
    logic [31:0] n_aluout, n_pc, n_wdata, n_badvaddr;
    logic [4:0]  n_writereg, n_excode;
    logic [3:0]  n_wen;

    logic        r_valid, r_regwrite, r_en, r_exc;
    logic [31:0] r_aluout, r_pc, r_wdata, r_badvaddr;
    logic [4:0]  r_writereg, r_excode;
    logic [3:0]  r_wen;

    assign addr = bus.ex_aluout;

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_half   = 1'b0;
        is_word   = 1'b0;
        wen_raw   = '0;
        wdata_raw = '0;
        case (bus.ex_alucontrol)
            OP_LB, OP_LBU: is_load = 1'b1;
            OP_LH, OP_LHU: begin is_load = 1'b1; is_half = 1'b1; end
            OP_LW:         begin is_load = 1'b1; is_word = 1'b1; end
            OP_SB: begin
                is_store  = 1'b1;
                wdata_raw = {4{bus.ex_rtvalue[7:0]}};
                wen_raw   = 4'b0001 << addr[1:0];
            end
            OP_SH: begin
                is_store  = 1'b1;
                is_half   = 1'b1;
                wdata_raw = {2{bus.ex_rtvalue[15:0]}};
                wen_raw   = addr[1] ? 4'b1100 : 4'b0011;
            end
            OP_SW: begin
                is_store  = 1'b1;
                is_word   = 1'b1;
                wdata_raw = bus.ex_rtvalue;
                wen_raw   = 4'b1111;
            end
            default: ;
        endcase
        addr_err = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
        exc      = bus.ex_overflow | addr_err;
    end

    // Overflow outranks an address error and suppresses the bad-address report.
    always_comb begin
        n_valid    = 1'b0;
        n_aluout   = '0;
        n_writereg = '0;
        n_regwrite = 1'b0;
        n_pc       = '0;
        n_en       = 1'b0;
        n_wen      = '0;
        n_wdata    = '0;
        n_exc      = 1'b0;
        n_excode   = '0;
        n_badvaddr = '0;
        if (bus.ex_valid) begin
            n_valid    = 1'b1;
            n_aluout   = bus.ex_aluout;
            n_writereg = bus.ex_writereg;
            n_pc       = bus.ex_pc;
            n_wdata    = wdata_raw;
            n_exc      = exc;
            n_regwrite = bus.ex_regwrite & ~exc;
            n_en       = (is_load | is_store) & ~exc;
            n_wen      = exc ? 4'b0000 : wen_raw;
            if (bus.ex_overflow) begin
                n_excode = EXC_OV;
            end else if (addr_err) begin
                n_excode   = is_load ? EXC_ADEL : EXC_ADES;
                n_badvaddr = addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_valid    <= 1'b0;
            r_aluout   <= '0;
            r_writereg <= '0;
            r_regwrite <= 1'b0;
            r_pc       <= '0;
            r_en       <= 1'b0;
            r_wen      <= '0;
            r_wdata    <= '0;
            r_exc      <= 1'b0;
            r_excode   <= '0;
            r_badvaddr <= '0;
        end else if (!bus.stall) begin
            r_valid    <= n_valid;
            r_aluout   <= n_aluout;
            r_writereg <= n_writereg;
            r_regwrite <= n_regwrite;
            r_pc       <= n_pc;
            r_en       <= n_en;
            r_wen      <= n_wen;
            r_wdata    <= n_wdata;
            r_exc      <= n_exc;
            r_excode   <= n_excode;
            r_badvaddr <= n_badvaddr;
        end
    end

    assign bus.mem_valid    = r_valid;
    assign bus.mem_aluout   = r_aluout;
    assign bus.mem_writereg = r_writereg;
    assign bus.mem_regwrite = r_regwrite;
    assign bus.mem_pc       = r_pc;
    assign bus.mem_en       = r_en;
    assign bus.mem_wen      = r_wen;
    assign bus.mem_wdata    = r_wdata;
    assign bus.mem_exc      = r_exc;
    assign bus.mem_excode   = r_excode;
    assign bus.mem_badvaddr = r_badvaddr;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed vectors with literal expectations plus a
// randomized run compared every cycle against a behavioural model.
module tb_ex_mem_stage;
    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;
    localparam logic [7:0] OP_ADD = 8'b0010_0000;
    localparam logic [7:0] OP_OR  = 8'b0010_0101;

    typedef struct packed {
        logic        valid;
        logic [31:0] aluout;
        logic [4:0]  writereg;
        logic        regwrite;
        logic [31:0] pc;
        logic        en;
        logic [3:0]  wen;
        logic [31:0] wdata;
        logic        exc;
        logic [4:0]  excode;
        logic [31:0] badvaddr;
    } out_t;

    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_pass  = 0;
    out_t expq;

    ex_mem_if bus ();

    ex_mem_stage #(.EXC_OV(5'h0C), .EXC_ADEL(5'h04), .EXC_ADES(5'h05)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Expected MEM contents for one captured EX instruction, from the op's access size.
    function automatic out_t model(logic valid, logic [7:0] op, logic [31:0] addr,
                                   logic ov, logic [31:0] rt, logic [4:0] wr,
                                   logic regw, logic [31:0] pc);
        out_t o = '0;
        int   sz = 0;
        bit   ld = 0, st = 0, misal;
        case (op)
            OP_LB, OP_LBU: begin ld = 1; sz = 1; end
            OP_LH, OP_LHU: begin ld = 1; sz = 2; end
            OP_LW:         begin ld = 1; sz = 4; end
            OP_SB:         begin st = 1; sz = 1; end
            OP_SH:         begin st = 1; sz = 2; end
            OP_SW:         begin st = 1; sz = 4; end
            default: ;
        endcase
        if (!valid) return o;
        o.valid = 1; o.aluout = addr; o.writereg = wr; o.pc = pc;
        misal = (sz > 1) && ((addr % sz) != 0);
        if (ov) begin
            o.exc = 1; o.excode = 5'h0C;
        end else if (misal) begin
            o.exc = 1; o.excode = ld ? 5'h04 : 5'h05; o.badvaddr = addr;
        end
        if (st) begin
            case (sz)
                1: o.wdata = rt[7:0] * 32'h0101_0101;
                2: o.wdata = rt[15:0] * 32'h0001_0001;
                default: o.wdata = rt;
            endcase
        end
        if (!o.exc) begin
            o.regwrite = regw;
            o.en = ld | st;
            if (st) o.wen = 4'(((1 << sz) - 1) << ((addr % 4) - (addr % sz)));
        end
        return o;
    endfunction

    function automatic out_t actual();
        return '{bus.mem_valid, bus.mem_aluout, bus.mem_writereg, bus.mem_regwrite,
                 bus.mem_pc, bus.mem_en, bus.mem_wen, bus.mem_wdata, bus.mem_exc,
                 bus.mem_excode, bus.mem_badvaddr};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Model register: same update ordering as a pipeline register must obey.
    always @(posedge clk) begin
        if (rst || bus.flush) expq = '0;
        else if (!bus.stall)
            expq = model(bus.ex_valid, bus.ex_alucontrol, bus.ex_aluout, bus.ex_overflow,
                         bus.ex_rtvalue, bus.ex_writereg, bus.ex_regwrite, bus.ex_pc);
    end

    always @(negedge clk) begin
        out_t a;
        a = actual();
        n_total++;
        if (a === expq) n_pass++;
        else $display("FAIL model t=%0t: got %h expected %h", $time, a, expq);
    end

    task automatic drive(logic [7:0] op, logic [31:0] addr, logic [31:0] rt,
                         logic ov, logic regw);
        bus.ex_valid      = 1'b1;
        bus.ex_alucontrol = op;
        bus.ex_aluout     = addr;
        bus.ex_rtvalue    = rt;
        bus.ex_overflow   = ov;
        bus.ex_regwrite   = regw;
        bus.ex_writereg   = 5'd9;
        bus.ex_pc         = 32'h0040_0010;
    endtask

    task automatic step();
        @(negedge clk); #1;
    endtask

    function automatic logic [7:0] rand_op();
        logic [7:0] ops [10];
        ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, OP_ADD, OP_OR};
        return ops[$urandom_range(9)];
    endfunction

    initial begin
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(OP_SW, 32'h100, 32'h1, 1'b0, 1'b0);
        step(); step();
        check("reset_valid", 32'(bus.mem_valid), 32'd0);
        check("reset_wen", 32'(bus.mem_wen), 32'd0);
        rst = 1'b0;

        drive(OP_SW, 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b0);
        step();
        check("sw_en", 32'(bus.mem_en), 32'd1);
        check("sw_wen", 32'(bus.mem_wen), 32'hF);
        check("sw_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        check("sw_exc", 32'(bus.mem_exc), 32'd0);

        drive(OP_SB, 32'h103, 32'h0000_00A5, 1'b0, 1'b0);
        step();
        check("sb_wen", 32'(bus.mem_wen), 32'h8);
        check("sb_wdata", bus.mem_wdata, 32'hA5A5_A5A5);

        drive(OP_LW, 32'h102, 32'h0, 1'b0, 1'b1);
        step();
        check("lw_ade_exc", 32'(bus.mem_exc), 32'd1);
        check("lw_ade_code", 32'(bus.mem_excode), 32'h04);
        check("lw_ade_bad", bus.mem_badvaddr, 32'h102);
        check("lw_ade_en", 32'(bus.mem_en), 32'd0);
        check("lw_ade_regw", 32'(bus.mem_regwrite), 32'd0);
        check("lw_ade_valid", 32'(bus.mem_valid), 32'd1);

        drive(OP_ADD, 32'h7, 32'h0, 1'b1, 1'b1);
        step();
        check("ov_exc", 32'(bus.mem_exc), 32'd1);
        check("ov_code", 32'(bus.mem_excode), 32'h0C);
        check("ov_regw", 32'(bus.mem_regwrite), 32'd0);

        drive(OP_SH, 32'h202, 32'h1234_5678, 1'b0, 1'b0);
        step();
        check("sh_wen", 32'(bus.mem_wen), 32'hC);
        check("sh_wdata", bus.mem_wdata, 32'h5678_5678);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(OP_SW, $urandom & 32'hFFFF_FFFC, $urandom, 1'b0, 1'b1);
            step();
            check("stall_hold_wen", 32'(bus.mem_wen), 32'hC);
        end
        bus.flush = 1'b1;
        step();
        check("stall_flush_valid", 32'(bus.mem_valid), 32'd0);
        check("stall_flush_aluout", bus.mem_aluout, 32'd0);
        bus.flush = 1'b0;
        bus.stall = 1'b0;

        drive(OP_SW, 32'h300, 32'hCAFE_F00D, 1'b0, 1'b0);
        step();
        bus.stall = 1'b1;
        rst = 1'b1;
        step();
        check("rst_in_stall_valid", 32'(bus.mem_valid), 32'd0);
        check("rst_in_stall_wdata", bus.mem_wdata, 32'd0);
        check("rst_in_stall_wen", 32'(bus.mem_wen), 32'd0);
        rst = 1'b0;
        bus.stall = 1'b0;
        drive(OP_LW, 32'h200, 32'h0, 1'b0, 1'b1);
        step();
        check("post_rst_en", 32'(bus.mem_en), 32'd1);
        check("post_rst_aluout", bus.mem_aluout, 32'h200);
        check("post_rst_regw", 32'(bus.mem_regwrite), 32'd1);

        for (int i = 0; i < 3000; i++) begin
            bus.ex_valid      = ($urandom_range(9) != 0);
            bus.ex_alucontrol = rand_op();
            bus.ex_aluout     = $urandom;
            bus.ex_rtvalue    = $urandom;
            bus.ex_overflow   = ($urandom_range(7) == 0);
            bus.ex_regwrite   = 1'($urandom);
            bus.ex_writereg   = 5'($urandom);
            bus.ex_pc         = $urandom;
            bus.stall         = ($urandom_range(4) == 0);
            bus.flush         = ($urandom_range(9) == 0);
            rst               = ($urandom_range(49) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
